// File: rtl/result_collector.sv
// ============================================================================
//  Module   : result_collector
//  Purpose  : Buffers per-neuron accumulator results written by the compute
//             array during a layer, then drains them in index order as
//             requantized words over a valid/ready stream.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk          in   clock, all logic on the rising edge
//    rst          in   synchronous active-high reset
//    res_wr_en    in   result write strobe
//    res_wr_addr  in   neuron index of the write        [ADDR_WIDTH]
//    res_wr_data  in   signed accumulator value         [2*DATA_WIDTH]
//    layer_done   in   level, high once all results of the layer are written
//    shift        in   requantization right-shift amount [5]
//    out_valid    out  output word valid
//    out_ready    in   downstream accept
//    out_data     out  signed requantized result        [DATA_WIDTH]
//    out_addr     out  neuron index of out_data         [ADDR_WIDTH]
//    out_last     out  high with the word at index NUM_NEURONS-1
//    busy         out  high while draining
//    wr_err       out  sticky flag for dropped writes (cleared only by rst)
//
//  Build option
//    RESULT_RELU_EN : when defined, negative accumulators are clamped to zero
//                     before rounding; otherwise they pass through signed.
// ============================================================================
`default_nettype none

module result_collector #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_NEURONS = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    res_wr_en,
  input  logic [ADDR_WIDTH-1:0]   res_wr_addr,
  input  logic [2*DATA_WIDTH-1:0] res_wr_data,
  input  logic                    layer_done,
  input  logic [4:0]              shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic                    out_last,
  output logic                    busy,
  output logic                    wr_err
);

  localparam int          ACC_W  = 2 * DATA_WIDTH;
  localparam int          WIDE_W = ACC_W + 1;
  localparam int          IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int          CNT_W  = $clog2(NUM_NEURONS + 1);
  localparam logic [31:0] NUM_U  = 32'(NUM_NEURONS);

  localparam logic [1:0] S_COLLECT  = 2'd0;
  localparam logic [1:0] S_DRAIN    = 2'd1;
  localparam logic [1:0] S_WAIT_CLR = 2'd2;

  // Saturation bounds expressed at the widened requantization width.
  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    $signed({{(WIDE_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [WIDE_W-1:0] SAT_MIN =
    $signed({{(WIDE_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

  logic [ACC_W-1:0]      mem_q [NUM_NEURONS];

  logic [1:0]            state_q, state_d;
  logic [4:0]            shift_q;
  logic [CNT_W-1:0]      rd_ptr_q;

  // Stage 1: registered buffer read (prefetch slot).
  logic                  s1_vld_q;
  logic [ACC_W-1:0]      s1_data_q;
  logic [ADDR_WIDTH-1:0] s1_idx_q;

  // Stage 2: output register.
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  out_last_q;
  logic                  wr_err_q;

  logic w_in_range, w_wr_ok, w_wr_drop, w_xfer, w_s2_ld, w_s1_free, w_issue;
  logic w_last_idx;

  assign w_in_range = 32'(res_wr_addr) < NUM_U;
  assign w_wr_ok    = res_wr_en && (state_q == S_COLLECT) && w_in_range;
  assign w_wr_drop  = res_wr_en && !w_wr_ok;
  assign w_xfer     = out_valid_q && out_ready;
  // The output register takes a new word when it is empty or being emptied.
  assign w_s2_ld    = s1_vld_q && (!out_valid_q || out_ready);
  // The read slot can accept a new read when empty or handing off this cycle;
  // this keeps one word per cycle flowing with ready held high.
  assign w_s1_free  = !s1_vld_q || w_s2_ld;
  assign w_issue    = (state_q == S_DRAIN) && (32'(rd_ptr_q) < NUM_U) && w_s1_free;
  assign w_last_idx = (s1_idx_q == ADDR_WIDTH'(NUM_NEURONS - 1));

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT:  if (layer_done)          state_d = S_DRAIN;
      S_DRAIN:    if (w_xfer && out_last_q) state_d = S_WAIT_CLR;
      S_WAIT_CLR: if (!layer_done)         state_d = S_COLLECT;
      default:                             state_d = S_COLLECT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Requantization of the word sitting in the read slot
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  w_x;
  logic signed [WIDE_W-1:0] w_x_wide;
  logic signed [WIDE_W-1:0] w_rnd;
  logic signed [WIDE_W-1:0] w_sum;
  logic signed [WIDE_W-1:0] w_t;
  logic [DATA_WIDTH-1:0]    w_req;

  always_comb begin
    w_x = $signed(s1_data_q);
`ifdef RESULT_RELU_EN
    if (w_x < 0) begin
      w_x = '0;
    end
`endif
    w_x_wide = $signed({w_x[ACC_W-1], w_x});
    w_rnd    = '0;
    if (shift_q != 5'd0) begin
      w_rnd = $signed(WIDE_W'(1) << (shift_q - 5'd1));
    end
    // One extra bit keeps x + 2^(shift-1) from overflowing at the top of range.
    w_sum = w_x_wide + w_rnd;
    w_t   = w_sum >>> shift_q;
    if (w_t > SAT_MAX) begin
      w_req = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_t < SAT_MIN) begin
      w_req = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      w_req = w_t[DATA_WIDTH-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Result buffer: no reset, contents survive rst
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[IDX_W'(res_wr_addr)] <= res_wr_data;
    end
    if (w_issue) begin
      s1_data_q <= mem_q[IDX_W'(rd_ptr_q)];
    end
  end

  // --------------------------------------------------------------------------
  // State, read pointer and output pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_COLLECT;
      shift_q     <= '0;
      rd_ptr_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (w_wr_drop) begin
        wr_err_q <= 1'b1;
      end

      if (state_q == S_COLLECT) begin
        rd_ptr_q <= '0;
        s1_vld_q <= 1'b0;
        // Shift is frozen for the whole drain from the entry cycle on.
        if (layer_done) begin
          shift_q <= shift;
        end
      end else begin
        if (w_issue) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          s1_idx_q <= ADDR_WIDTH'(rd_ptr_q);
          s1_vld_q <= 1'b1;
        end else if (w_s2_ld) begin
          s1_vld_q <= 1'b0;
        end
      end

      if (w_s2_ld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= w_req;
        out_addr_q  <= s1_idx_q;
        out_last_q  <= w_last_idx;
      end else if (w_xfer) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == S_DRAIN);
  assign wr_err    = wr_err_q;

endmodule

`default_nettype wire

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, result address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of the requantized output word; the input accumulator is 2*DATA_WIDTH bits.
REQ-003 SHALL have parameter NUM_NEURONS, default 512, buffer depth and number of results drained per layer.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port res_wr_en, input, 1, result write strobe.
REQ-007 SHALL have port res_wr_addr, input, ADDR_WIDTH, neuron index of the write.
REQ-008 SHALL have port res_wr_data, input, 2*DATA_WIDTH, signed accumulator value.
REQ-009 SHALL have port layer_done, input, 1, level from the layer controller; high means all results have been written.
REQ-010 SHALL have port shift, input, 5, requantization right-shift amount.
REQ-011 SHALL have port out_valid, output, 1, output word valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accept.
REQ-013 SHALL have port out_data, output, DATA_WIDTH, signed requantized result.
REQ-014 SHALL have port out_addr, output, ADDR_WIDTH, neuron index of out_data.
REQ-015 SHALL have port out_last, output, 1, high with the word at index NUM_NEURONS-1.
REQ-016 SHALL have port busy, output, 1, high in DRAIN.
REQ-017 SHALL have port wr_err, output, 1, sticky flag for dropped writes.

Function
REQ-018 SHALL implement FSM states COLLECT, DRAIN and WAIT_CLR.
- COLLECT -> DRAIN when layer_done=1.
- DRAIN -> WAIT_CLR after the handshake of the last word.
- WAIT_CLR -> COLLECT when layer_done=0.
REQ-019 In COLLECT, when res_wr_en=1 and res_wr_addr<NUM_NEURONS, the block SHALL write res_wr_data into buffer[res_wr_addr]; a later write to the same address overwrites the earlier one.
REQ-020 SHALL drop a write whose address is >= NUM_NEURONS, or any write arriving in DRAIN or WAIT_CLR, and set wr_err.
REQ-021 If res_wr_en and layer_done are high in the same COLLECT cycle, the block SHALL store the write before draining.
REQ-022 SHALL capture shift on entry to DRAIN and hold it constant for the whole drain.
REQ-023 SHALL read the buffer with one-cycle read latency. The first out_valid SHALL assert 2 cycles after layer_done is sampled high. Addresses SHALL be presented in order 0..NUM_NEURONS-1.
REQ-024 Handshake: a word transfers when out_valid && out_ready.
- While out_valid && !out_ready, out_data, out_addr and out_last SHALL hold stable.
- out_valid SHALL never deassert without a transfer.
REQ-025 SHALL sustain one word per cycle while out_ready stays high (prefetch/skid register); a full drain with no backpressure takes NUM_NEURONS+1 cycles from entry to last transfer.
REQ-026 Requantization SHALL be computed at 2*DATA_WIDTH+1 bits:
- shift=0: t = x.
- shift>0: t = (x + 2^(shift-1)) >>> shift (arithmetic shift, round half up).
- out_data = t saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-027 busy SHALL equal (state==DRAIN).

Reset
REQ-028 After rst the block SHALL be in COLLECT, with out_valid=0, out_last=0, out_data=0, out_addr=0, busy=0 and wr_err=0.
REQ-029 Asserting rst mid-drain SHALL abort the drain with no further transfers; buffer contents are not cleared and are undefined until rewritten.
REQ-030 rst SHALL be the only way to clear wr_err.

Configuration
REQ-031 With macro RESULT_RELU_EN defined, the block SHALL clamp negative x to 0 before rounding. Without the macro, negative values SHALL pass through signed.

Verification
REQ-032 Write addr k with value k*256 for k=0..511, shift=8, pulse layer_done -> 512 words with out_data=k, out_addr=k, out_last only at k=511.
REQ-033 Write 0x7FFF_FFFF, shift=0 -> out_data=0x7FFF (saturated); write 0x8000_0000 -> out_data=0x8000.
REQ-034 Write -3, shift=1 -> out_data=-1 without RESULT_RELU_EN and 0 with it; write 3, shift=1 -> out_data=2.
REQ-035 Drive out_ready with a random 30% duty cycle -> no lost or duplicated words, outputs stable while stalled, throughput 1/cycle once ready is held high.
REQ-036 Write to addr 600, then write during DRAIN -> wr_err=1 and the buffer and output sequence are unchanged.
REQ-037 Assert rst after 100 transfers -> out_valid=0 and busy=0 the next cycle; a new layer then drains correctly.
